// File: rtl/arb_req_agent5.sv
// arb_req_agent5: requester-side agent for a 5-client, 2-grant arbiter.
// Optional starvation monitor (starve_out port) is enabled by defining ARB_REQ_STARVE_EN.
module arb_req_agent5 #(
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 3,
  parameter int MAX_GRANT    = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] post_in,
  output logic [4:0] full_out,
  output logic [4:0] req_out,
  output logic       req_valid,
  input  logic [4:0] grant_in,
  output logic [4:0] done_out,
  output logic       proto_err
`ifdef ARB_REQ_STARVE_EN
  ,
  output logic [4:0] starve_out
`endif
);

  localparam int N = 5;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [2:0]       MAXG_C  = 3'(MAX_GRANT);

  function automatic logic [2:0] popcount5(input logic [N-1:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int k = 0; k < N; k++) begin
      s = s + {2'b00, v[k]};
    end
    return s;
  endfunction

  logic [CNT_W-1:0] pending   [N];
  logic [CNT_W-1:0] pend_next [N];
  logic [N-1:0]     req_q;
  logic [N-1:0]     g;
  logic [N-1:0]     has_next;
  logic             over_grant;
  logic             stray_grant;

  // Full flags straight from the pending counters.
  always_comb begin
    full_out = 5'b00000;
    for (int i = 0; i < N; i++) begin
      full_out[i] = (pending[i] == DEPTH_C);
    end
  end

  // Grant qualification, protocol checks and next pending count.
  always_comb begin
    g           = grant_in & req_q;
    over_grant  = (popcount5(grant_in) > MAXG_C);
    stray_grant = |(grant_in & ~req_q);
    has_next    = 5'b00000;
    for (int i = 0; i < N; i++) begin
      pend_next[i] = pending[i];
      // A post and a grant together cancel, even on a full client.
      if (post_in[i] && g[i]) begin
        pend_next[i] = pending[i];
      end else if (post_in[i] && (pending[i] != DEPTH_C)) begin
        pend_next[i] = pending[i] + ONE_C;
      end else if (g[i] && (pending[i] != ZERO_C)) begin
        pend_next[i] = pending[i] - ONE_C;
      end else begin
        pend_next[i] = pending[i];
      end
      has_next[i] = (pend_next[i] != ZERO_C);
    end
  end

  // Counters, request/grant pipeline and sticky protocol flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pending[i] <= ZERO_C;
      end
      req_out   <= 5'b00000;
      req_q     <= 5'b00000;
      done_out  <= 5'b00000;
      proto_err <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        pending[i] <= pend_next[i];
      end
      // A request in flight suppresses re-request, so each client asks every other cycle.
      req_out   <= has_next & ~req_out;
      req_q     <= req_out;
      done_out  <= g;
      proto_err <= proto_err | over_grant | stray_grant;
    end
  end

  assign req_valid = |req_out;

`ifdef ARB_REQ_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SZERO_C = {SW{1'b0}};
  localparam logic [SW-1:0] SONE_C  = SW'(1);

  logic [SW-1:0] starve_cnt [N];

  // Saturating count of cycles a client waits with work pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        starve_cnt[i] <= SZERO_C;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (g[i] || (pending[i] == ZERO_C)) begin
          starve_cnt[i] <= SZERO_C;
        end else if (starve_cnt[i] != LIMIT_C) begin
          starve_cnt[i] <= starve_cnt[i] + SONE_C;
        end else begin
          starve_cnt[i] <= starve_cnt[i];
        end
      end
    end
  end

  // Starvation flag while the counter sits at its limit.
  always_comb begin
    starve_out = 5'b00000;
    for (int i = 0; i < N; i++) begin
      starve_out[i] = (starve_cnt[i] == LIMIT_C);
    end
  end
`endif

endmodule

// File: tb/tb_arb_req_agent5.sv
// Self-checking bench for arb_req_agent5: done_out is checked against a due-cycle queue,
// the remaining outputs inline in each scenario task.
module tb_arb_req_agent5;

  logic       clk;
  logic       rst;
  logic [4:0] post_in;
  logic [4:0] full_out;
  logic [4:0] req_out;
  logic       req_valid;
  logic [4:0] grant_in;
  logic [4:0] done_out;
  logic       proto_err;
`ifdef ARB_REQ_STARVE_EN
  logic [4:0] starve_out;
`endif

  typedef struct {
    int         due;
    logic [4:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  arb_req_agent5 dut (
    .clk       (clk),
    .rst       (rst),
    .post_in   (post_in),
    .full_out  (full_out),
    .req_out   (req_out),
    .req_valid (req_valid),
    .grant_in  (grant_in),
    .done_out  (done_out),
    .proto_err (proto_err)
`ifdef ARB_REQ_STARVE_EN
    ,
    .starve_out(starve_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected done_out for the cycle after the grant currently driven.
  task automatic push_done(input logic [4:0] val);
    exp_t e;
    e.due = cyc + 1;
    e.val = val;
    sbq.push_back(e);
  endtask

  // Advance one clock and pop the scoreboard against done_out.
  task automatic tick();
    logic [4:0] exp;
    @(posedge clk);
    #1;
    cyc++;
    exp = 5'h00;
    if (sbq.size() != 0 && sbq[0].due == cyc) begin
      exp = sbq[0].val;
      void'(sbq.pop_front());
    end
    total++;
    if (done_out !== exp) begin
      bad++;
      $display("FAIL done_out cyc=%0d actual=%h required=%h", cyc, done_out, exp);
    end
  endtask

  task automatic reset_dut();
    rst      = 1'b1;
    post_in  = 5'h00;
    grant_in = 5'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    post_in  = 5'h00;
    grant_in = 5'h00;
    tick();
    tick();
    total++;
    if (req_out !== 5'h00 || req_valid !== 1'b0 || full_out !== 5'h00 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_state actual=req %h val %b full %h perr %b required=0,0,0,0",
               req_out, req_valid, full_out, proto_err);
    end
    rst = 1'b0;
    tick();
    total++;
    if (req_out !== 5'h00 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle actual=req %h perr %b required=00,0", req_out, proto_err);
    end
  endtask

  task automatic test_single();
    post_in = 5'h01;
    tick();
    total++;
    if (req_out !== 5'h01 || req_valid !== 1'b1) begin
      bad++;
      $display("FAIL single_req actual=%h/%b required=01/1", req_out, req_valid);
    end
    post_in = 5'h00;
    tick();
    total++;
    if (req_out !== 5'h00) begin
      bad++;
      $display("FAIL single_inflight actual=%h required=00", req_out);
    end
    grant_in = 5'h01;
    push_done(5'h01);
    tick();
    grant_in = 5'h00;
    total++;
    if (req_out !== 5'h00 || req_valid !== 1'b0 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL single_retire actual=req %h perr %b required=00,0", req_out, proto_err);
    end
    tick();
    total++;
    if (req_out !== 5'h00) begin
      bad++;
      $display("FAIL single_drained actual=%h required=00", req_out);
    end
  endtask

  task automatic test_pattern();
    logic [4:0] pp [9];
    logic [4:0] gg [9];
    logic [4:0] rr [9];
    pp = '{5'h1a, 5'h1a, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
    gg = '{5'h00, 5'h00, 5'h12, 5'h00, 5'h08, 5'h00, 5'h12, 5'h00, 5'h08};
    rr = '{5'h1a, 5'h00, 5'h1a, 5'h00, 5'h1a, 5'h00, 5'h08, 5'h00, 5'h00};
    for (int k = 0; k < 9; k++) begin
      post_in  = pp[k];
      grant_in = gg[k];
      if (gg[k] != 5'h00) push_done(gg[k]);
      tick();
      total++;
      if (req_out !== rr[k]) begin
        bad++;
        $display("FAIL pattern_req step=%0d actual=%h required=%h", k, req_out, rr[k]);
      end
    end
    post_in  = 5'h00;
    grant_in = 5'h00;
    tick();
    total++;
    if (req_out !== 5'h00 || proto_err !== 1'b0 || full_out !== 5'h00) begin
      bad++;
      $display("FAIL pattern_end actual=req %h perr %b full %h required=00,0,00",
               req_out, proto_err, full_out);
    end
  endtask

  task automatic test_fill();
    logic [4:0] ff [5];
    ff = '{5'h00, 5'h00, 5'h00, 5'h04, 5'h04};
    for (int k = 0; k < 5; k++) begin
      post_in = 5'h04;
      tick();
      total++;
      if (full_out !== ff[k]) begin
        bad++;
        $display("FAIL fill_full post=%0d actual=%h required=%h", k + 1, full_out, ff[k]);
      end
    end
    post_in = 5'h00;
    tick();
    grant_in = 5'h04;
    push_done(5'h04);
    tick();
    grant_in = 5'h00;
    total++;
    if (full_out !== 5'h00) begin
      bad++;
      $display("FAIL fill_after_grant actual=%h required=00", full_out);
    end
    post_in = 5'h04;
    tick();
    post_in = 5'h00;
    total++;
    if (full_out !== 5'h04) begin
      bad++;
      $display("FAIL fill_pending3 actual=%h required=04", full_out);
    end
  endtask

  task automatic test_simul();
    reset_dut();
    for (int k = 0; k < 4; k++) begin
      post_in = 5'h08;
      tick();
    end
    total++;
    if (full_out !== 5'h08 || req_out !== 5'h00) begin
      bad++;
      $display("FAIL simul_full actual=full %h req %h required=08,00", full_out, req_out);
    end
    post_in  = 5'h08;
    grant_in = 5'h08;
    push_done(5'h08);
    tick();
    post_in  = 5'h00;
    grant_in = 5'h00;
    total++;
    if (full_out !== 5'h08 || req_out !== 5'h08) begin
      bad++;
      $display("FAIL simul_hold actual=full %h req %h required=08,08", full_out, req_out);
    end
    tick();
    grant_in = 5'h08;
    push_done(5'h08);
    tick();
    grant_in = 5'h00;
    total++;
    if (full_out !== 5'h00 || proto_err !== 1'b0) begin
      bad++;
      $display("FAIL simul_drain actual=full %h perr %b required=00,0", full_out, proto_err);
    end
  endtask

  task automatic test_proto();
    reset_dut();
    post_in = 5'h07;
    tick();
    post_in = 5'h00;
    tick();
    grant_in = 5'h07;
    push_done(5'h07);
    tick();
    grant_in = 5'h00;
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_overgrant actual=%b required=1", proto_err);
    end
    tick();
    tick();
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_sticky actual=%b required=1", proto_err);
    end
    reset_dut();
    total++;
    if (proto_err !== 1'b0) begin
      bad++;
      $display("FAIL proto_cleared actual=%b required=0", proto_err);
    end
    grant_in = 5'h02;
    tick();
    grant_in = 5'h00;
    total++;
    if (proto_err !== 1'b1) begin
      bad++;
      $display("FAIL proto_stray actual=%b required=1", proto_err);
    end
    tick();
  endtask

`ifdef ARB_REQ_STARVE_EN
  task automatic test_starve();
    reset_dut();
    post_in = 5'h10;
    tick();
    post_in = 5'h00;
    for (int k = 2; k <= 16; k++) begin
      tick();
      total++;
      if (starve_out !== 5'h00) begin
        bad++;
        $display("FAIL starve_early cycle=%0d actual=%h required=00", k, starve_out);
      end
    end
    tick();
    total++;
    if (starve_out !== 5'h10) begin
      bad++;
      $display("FAIL starve_set actual=%h required=10", starve_out);
    end
    tick();
    grant_in = 5'h10;
    push_done(5'h10);
    tick();
    grant_in = 5'h00;
    total++;
    if (starve_out !== 5'h00) begin
      bad++;
      $display("FAIL starve_clear actual=%h required=00", starve_out);
    end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    post_in  = 5'h00;
    grant_in = 5'h00;
    test_reset();
    test_single();
    test_pattern();
    test_fill();
    test_simul();
    test_proto();
`ifdef ARB_REQ_STARVE_EN
    test_starve();
`endif
    tick();
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb_req_agent5.md
# arb_req_agent5

Requester-side agent for the 5-client, 2-grant arbiter. Five clients post jobs into per-client pending counters. The agent presents the request vector and request-valid to the arbiter, then consumes the returned grant vector, retiring one job per granted client. It also checks the grant protocol. The block sits between client logic and the arbiter's request/grant port.

## Interface
- DEPTH, 4, max pending jobs per client (1..7)
- CNT_W, 3, pending-counter width; must hold DEPTH
- MAX_GRANT, 2, max grant bits legal in one cycle
- STARVE_LIMIT, 16, cycles of unserved pending before starvation flag (used only with macro)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- post_in  in  5  per-client job post, one job per set bit per cycle
- full_out  out  5  bit i high when pending[i] == DEPTH
- req_out  out  5  registered request vector to arbiter
- req_valid  out  1  OR of req_out
- grant_in  in  5  grant vector from arbiter; answers req_out of previous cycle
- done_out  out  5  registered one-cycle pulse per retired job
- proto_err  out  1  sticky grant-protocol violation
- starve_out  out  5  per-client starvation flag (present only with ARB_REQ_STARVE_EN)

## Operation
- State per client i: pending[i] (CNT_W bits), req_q[i] (req_out delayed one cycle). Optional starvation counter starve_cnt[i].
- Valid grant: g = grant_in & req_q. Bits outside req_q are ignored.
- Pending update:
  - post (when not full) increments pending[i].
  - g[i] decrements pending[i].
  - Post and grant in the same cycle leave pending[i] unchanged, including at DEPTH.
- Post to a full client with no grant that cycle is dropped silently. Clients must check full_out.
- Request rule: req_out[i] <= (pend_next[i] != 0) && !req_out[i].
  - A client requests at most every other cycle.
  - While a request is in flight, req_out[i] is 0 and the cycle's grant_in is checked.
  - An ungranted request is re-issued the following cycle if jobs remain.
- done_out <= g.
- req_valid = |req_out (combinational from register).
- proto_err sets when either condition holds, and stays set until rst:
  - popcount(grant_in) > MAX_GRANT, or
  - (grant_in & ~req_q) != 0.
- Masked grant bits are still applied when proto_err fires.
- Reset values:
  - pending = 0, req_out = 0, req_q = 0, done_out = 0, proto_err = 0.
  - full_out = 0, req_valid = 0, starve_out = 0, starve_cnt = 0.
- rst mid-operation discards all pending jobs and in-flight requests. Grants arriving the cycle after reset deassertion see req_q = 0, so any set bit flags proto_err.

## Timing
- post_in sampled at edge E → pending and req_out visible after E (latency 1).
- Request high in cycle t → grant_in evaluated in cycle t+1 → done_out pulse and pending decrement visible in cycle t+2.
- Peak throughput: one job per client per 2 cycles. Aggregate throughput is bounded by MAX_GRANT.
- full_out is combinational from pending. It updates the cycle after the causing post or grant.
- All 5 clients may request simultaneously. No internal priority exists; arbitration belongs to the arbiter.

## Configuration
- ARB_REQ_STARVE_EN defined:
  - starve_cnt[i] increments each cycle pending[i] != 0 and g[i] == 0.
  - The counter clears on g[i] or when pending[i] == 0, and saturates at STARVE_LIMIT.
  - starve_out[i] is high while starve_cnt[i] == STARVE_LIMIT and clears the cycle after a grant.
- Not defined: starve_out port and counters are absent; all other behaviour is identical.

## Test plan
- Reset then single post: post_in=5'h01 for one cycle, grant_in=5'h01 the cycle after req_out=5'h01 → req_out 01,00; done_out=5'h01 one cycle later; pending[0]=0; proto_err=0.
- Pattern 5'h1a posted twice, arbiter grants 5'h12 then 5'h08 → done_out 5'h12 then 5'h08. Clients 1 and 4 re-request for their second job; pending reaches 0 for all after four grants.
- Fill client 2: post 5'h04 for 5 cycles with no grants → full_out[2]=1 after the 4th post; 5th post dropped; after one grant pending[2]=3.
- Simultaneous post and grant to client 3 at pending=DEPTH → pending stays 4, full_out[3] stays 1, done_out[3] pulses.
- Protocol errors: grant_in=5'h07 against req_q=5'h07 → proto_err=1 and sticky. After rst, grant_in=5'h02 with req_q=0 → proto_err=1 and no done_out.
- With ARB_REQ_STARVE_EN, STARVE_LIMIT=16: post 5'h10, never grant → starve_out[4]=1 from cycle 17 after pending set; grant → starve_out[4]=0 next cycle.
